// File: rtl/riscv_config_pkg.sv
// Shared L1 cache configuration: line geometry, MESI states, coherency request
// kinds and the snoop state-transition helpers used by the snoop responder.
package riscv_config_pkg;

    localparam int CONFIG_CACHE_LINE_SIZE = 32;
    localparam int L1_WORDS_PER_LINE      = CONFIG_CACHE_LINE_SIZE / 4;
    localparam int L1_WAYS                = 4;
    localparam int L1_WAY_WIDTH           = $clog2(L1_WAYS);

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    localparam addr_t LINE_MASK = ~addr_t'(CONFIG_CACHE_LINE_SIZE - 1);

    typedef enum logic [1:0] {
        CACHE_I = 2'd0,
        CACHE_S = 2'd1,
        CACHE_E = 2'd2,
        CACHE_M = 2'd3
    } cache_state_t;

    // Encoding 2'd3 is reserved; the responder treats it as a no-op snoop.
    typedef enum logic [1:0] {
        COH_READ_SHARED = 2'd0,
        COH_READ_EXCL   = 2'd1,
        COH_INVALIDATE  = 2'd2
    } coherency_req_type_e;

    function automatic cache_state_t snoop_next_state(
        input coherency_req_type_e req,
        input cache_state_t        cur,
        input logic                hit
    );
        cache_state_t nxt;
        nxt = cur;
        if (hit && (cur != CACHE_I)) begin
            case (req)
                COH_READ_SHARED: nxt = CACHE_S;
                COH_READ_EXCL:   nxt = CACHE_I;
                COH_INVALIDATE:  nxt = CACHE_I;
                default:         nxt = cur;
            endcase
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    function automatic logic snoop_needs_data(
        input coherency_req_type_e req,
        input cache_state_t        cur,
        input logic                hit
    );
        logic known;
        case (req)
            COH_READ_SHARED: known = 1'b1;
            COH_READ_EXCL:   known = 1'b1;
            COH_INVALIDATE:  known = 1'b1;
            default:         known = 1'b0;
        endcase
        return hit && (cur == CACHE_M) && known;
    endfunction

endpackage

// File: rtl/l1_snoop_responder.sv
// L1 snoop responder: arbitrates for the L1 arrays, looks up the snooped line,
// pulls dirty line data when required and issues a one-cycle snoop response.
module l1_snoop_responder
    import riscv_config_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   snoop_valid_i,
    output logic                                   snoop_ready_o,
    input  addr_t                                  snoop_addr_i,
    input  coherency_req_type_e                    snoop_type_i,
    output logic                                   snoop_rsp_valid_o,
    output logic                                   snoop_rsp_data_en_o,
    output word_t [L1_WORDS_PER_LINE-1:0]          snoop_rsp_data_o,
    output logic                                   array_req_o,
    input  logic                                   array_gnt_i,
    output logic                                   array_lock_o,
    output logic                                   tag_rd_en_o,
    output addr_t                                  tag_rd_addr_o,
    input  logic                                   tag_rd_hit_i,
    input  logic [L1_WAY_WIDTH-1:0]                tag_rd_way_i,
    input  cache_state_t                           tag_rd_state_i,
    output logic                                   data_rd_en_o,
    output logic [L1_WAY_WIDTH-1:0]                data_rd_way_o,
    output addr_t                                  data_rd_addr_o,
    input  word_t                                  data_rd_data_i,
    output logic                                   state_wr_en_o,
    output addr_t                                  state_wr_addr_o,
    output logic [L1_WAY_WIDTH-1:0]                state_wr_way_o,
    output cache_state_t                           state_wr_state_o
);

    localparam int CNT_W = $clog2(L1_WORDS_PER_LINE + 1);
    localparam int IDX_W = $clog2(L1_WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L1_WORDS_PER_LINE);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_TAG_WAIT = 3'd2,
        ST_DATA     = 3'd3,
        ST_RESP     = 3'd4
    } fsm_state_e;

    fsm_state_e                       state_q;
    logic [CNT_W-1:0]                 cnt_q;
    addr_t                            addr_q;
    coherency_req_type_e              type_q;
    logic                             ready_q;
    logic                             array_req_q;
    logic                             lock_q;
    logic                             rsp_valid_q;
    logic                             data_en_q;
    word_t [L1_WORDS_PER_LINE-1:0]    buf_q;
    logic                             data_rd_en_q;
    logic [L1_WAY_WIDTH-1:0]          data_rd_way_q;
    addr_t                            data_rd_addr_q;
    logic                             wr_pend_q;
    logic                             state_wr_en_q;
    addr_t                            state_wr_addr_q;
    logic [L1_WAY_WIDTH-1:0]          state_wr_way_q;
    cache_state_t                     state_wr_state_q;

    cache_state_t                     next_state_s;
    logic                             needs_data_s;
    logic                             wr_needed_s;
    logic [IDX_W-1:0]                 buf_idx_s;
    addr_t                            next_word_addr_s;

    assign next_state_s     = snoop_next_state(type_q, tag_rd_state_i, tag_rd_hit_i);
    assign needs_data_s     = snoop_needs_data(type_q, tag_rd_state_i, tag_rd_hit_i);
    assign wr_needed_s      = tag_rd_hit_i && (next_state_s != tag_rd_state_i);
    // Word read at count k-1 returns during count k.
    assign buf_idx_s        = IDX_W'(cnt_q - CNT_W'(1));
    assign next_word_addr_s = addr_q + addr_t'({cnt_q + CNT_W'(1), 2'b00});

    // Snoop sequencing FSM with all handshake and array-port outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= CNT_W'(0);
            addr_q           <= 32'h0000_0000;
            type_q           <= COH_READ_SHARED;
            ready_q          <= 1'b0;
            array_req_q      <= 1'b0;
            lock_q           <= 1'b0;
            rsp_valid_q      <= 1'b0;
            data_en_q        <= 1'b0;
            buf_q            <= '0;
            data_rd_en_q     <= 1'b0;
            data_rd_way_q    <= '0;
            data_rd_addr_q   <= 32'h0000_0000;
            wr_pend_q        <= 1'b0;
            state_wr_en_q    <= 1'b0;
            state_wr_addr_q  <= 32'h0000_0000;
            state_wr_way_q   <= '0;
            state_wr_state_q <= CACHE_I;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (snoop_valid_i && ready_q) begin
                        addr_q      <= snoop_addr_i & LINE_MASK;
                        type_q      <= snoop_type_i;
                        ready_q     <= 1'b0;
                        array_req_q <= 1'b1;
                        state_q     <= ST_LOOKUP;
                    end else begin
                        ready_q     <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    if (array_gnt_i) begin
                        array_req_q <= 1'b0;
                        lock_q      <= 1'b1;
                        state_q     <= ST_TAG_WAIT;
                    end
                end
                ST_TAG_WAIT: begin
                    state_wr_addr_q  <= addr_q;
                    state_wr_way_q   <= tag_rd_way_i;
                    state_wr_state_q <= next_state_s;
                    wr_pend_q        <= wr_needed_s;
                    data_rd_way_q    <= tag_rd_way_i;
                    cnt_q            <= CNT_W'(0);
                    if (needs_data_s) begin
                        data_rd_en_q   <= 1'b1;
                        data_rd_addr_q <= addr_q;
                        state_q        <= ST_DATA;
                    end else begin
                        rsp_valid_q    <= 1'b1;
                        state_wr_en_q  <= wr_needed_s;
                        state_q        <= ST_RESP;
                    end
                end
                ST_DATA: begin
                    if (cnt_q != CNT_W'(0)) begin
                        buf_q[buf_idx_s] <= data_rd_data_i;
                    end
                    if (cnt_q == CNT_LAST) begin
                        data_rd_en_q  <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        data_en_q     <= 1'b1;
                        state_wr_en_q <= wr_pend_q;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q          <= cnt_q + CNT_W'(1);
                        data_rd_en_q   <= (cnt_q + CNT_W'(1)) != CNT_LAST;
                        data_rd_addr_q <= next_word_addr_s;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q   <= 1'b0;
                    data_en_q     <= 1'b0;
                    state_wr_en_q <= 1'b0;
                    lock_q        <= 1'b0;
                    ready_q       <= 1'b1;
                    cnt_q         <= CNT_W'(0);
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    ready_q     <= 1'b0;
                    array_req_q <= 1'b0;
                    lock_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign snoop_ready_o       = ready_q;
    assign snoop_rsp_valid_o   = rsp_valid_q;
    assign snoop_rsp_data_en_o = data_en_q;
    assign snoop_rsp_data_o    = buf_q;
    assign array_req_o         = array_req_q;
    assign array_lock_o        = lock_q;
    // Tag read must fire in the same cycle the grant arrives.
    assign tag_rd_en_o         = array_req_q & array_gnt_i;
    assign tag_rd_addr_o       = addr_q;
    assign data_rd_en_o        = data_rd_en_q;
    assign data_rd_way_o       = data_rd_way_q;
    assign data_rd_addr_o      = data_rd_addr_q;
    assign state_wr_en_o       = state_wr_en_q;
    assign state_wr_addr_o     = state_wr_addr_q;
    assign state_wr_way_o      = state_wr_way_q;
    assign state_wr_state_o    = state_wr_state_q;

endmodule

// File: tb/tb_l1_snoop_responder.sv
// Scoreboard bench for l1_snoop_responder: expected responses are queued when a
// snoop is driven and popped when the response pulse appears.
module tb_l1_snoop_responder;
    import riscv_config_pkg::*;

    localparam int W = L1_WORDS_PER_LINE;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        snoop_valid_i = 1'b0;
    logic                        snoop_ready_o;
    addr_t                       snoop_addr_i = 32'h0;
    coherency_req_type_e         snoop_type_i = COH_READ_SHARED;
    logic                        snoop_rsp_valid_o;
    logic                        snoop_rsp_data_en_o;
    word_t [W-1:0]               snoop_rsp_data_o;
    logic                        array_req_o;
    logic                        array_gnt_i = 1'b0;
    logic                        array_lock_o;
    logic                        tag_rd_en_o;
    addr_t                       tag_rd_addr_o;
    logic                        tag_rd_hit_i = 1'b0;
    logic [L1_WAY_WIDTH-1:0]     tag_rd_way_i = '0;
    cache_state_t                tag_rd_state_i = CACHE_I;
    logic                        data_rd_en_o;
    logic [L1_WAY_WIDTH-1:0]     data_rd_way_o;
    addr_t                       data_rd_addr_o;
    word_t                       data_rd_data_i = 32'h0;
    logic                        state_wr_en_o;
    addr_t                       state_wr_addr_o;
    logic [L1_WAY_WIDTH-1:0]     state_wr_way_o;
    cache_state_t                state_wr_state_o;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int                      lat;
        logic                    data_en;
        logic                    wr_en;
        cache_state_t            wr_state;
        logic [L1_WAY_WIDTH-1:0] wr_way;
        addr_t                   wr_addr;
        word_t [W-1:0]           data;
        int                      rd_cnt;
        int                      tag_cnt;
        int                      bad_way;
        logic                    lock_rsp;
        logic                    ready_seen;
        logic                    timeout;
    } rsp_t;

    rsp_t          exp_q[$];
    word_t [W-1:0] exp_buf = '0;

    l1_snoop_responder dut (
        .clk(clk), .rst(rst),
        .snoop_valid_i(snoop_valid_i), .snoop_ready_o(snoop_ready_o),
        .snoop_addr_i(snoop_addr_i), .snoop_type_i(snoop_type_i),
        .snoop_rsp_valid_o(snoop_rsp_valid_o), .snoop_rsp_data_en_o(snoop_rsp_data_en_o),
        .snoop_rsp_data_o(snoop_rsp_data_o),
        .array_req_o(array_req_o), .array_gnt_i(array_gnt_i), .array_lock_o(array_lock_o),
        .tag_rd_en_o(tag_rd_en_o), .tag_rd_addr_o(tag_rd_addr_o), .tag_rd_hit_i(tag_rd_hit_i),
        .tag_rd_way_i(tag_rd_way_i), .tag_rd_state_i(tag_rd_state_i),
        .data_rd_en_o(data_rd_en_o), .data_rd_way_o(data_rd_way_o),
        .data_rd_addr_o(data_rd_addr_o), .data_rd_data_i(data_rd_data_i),
        .state_wr_en_o(state_wr_en_o), .state_wr_addr_o(state_wr_addr_o),
        .state_wr_way_o(state_wr_way_o), .state_wr_state_o(state_wr_state_o)
    );

    always #5 clk = ~clk;

    // Data array model: one-cycle latency, word k of a line reads 0xA000_0000+k.
    always @(posedge clk) begin
        if (data_rd_en_o) data_rd_data_i <= 32'hA000_0000 + ((data_rd_addr_o & ~LINE_MASK) >> 2);
    end

    function automatic cache_state_t model_next(input logic [1:0] t, input logic hit, input cache_state_t s);
        if (!hit || s == CACHE_I) return s;
        if (t == 2'd0) return CACHE_S;
        if (t == 2'd1 || t == 2'd2) return CACHE_I;
        return s;
    endfunction

    function automatic rsp_t model_rsp(input logic [1:0] t, input addr_t a, input logic hit,
                                       input logic [L1_WAY_WIDTH-1:0] way, input cache_state_t s, input int stall);
        rsp_t e;
        logic dat;
        dat = hit && (s == CACHE_M) && (t != 2'd3);
        e.lat = (dat ? 4 + W : 3) + stall;
        e.data_en = dat;
        e.wr_state = model_next(t, hit, s);
        e.wr_en = hit && (e.wr_state != s);
        e.wr_way = way;
        e.wr_addr = {a[31:5], 5'd0};
        for (int k = 0; k < W; k++) e.data[k] = dat ? 32'hA000_0000 + k : exp_buf[k];
        e.rd_cnt = dat ? W : 0;
        e.tag_cnt = 1;
        e.bad_way = 0;
        e.lock_rsp = 1'b1;
        e.ready_seen = 1'b0;
        e.timeout = 1'b0;
        return e;
    endfunction

    task automatic drive_snoop(input logic [1:0] t, input addr_t a, input logic hit,
                               input logic [L1_WAY_WIDTH-1:0] way, input cache_state_t s);
        @(posedge clk); #1;
        tag_rd_hit_i = hit; tag_rd_way_i = way; tag_rd_state_i = s;
        snoop_addr_i = a; snoop_type_i = coherency_req_type_e'(t); snoop_valid_i = 1'b1;
        @(posedge clk); #1;
        snoop_valid_i = 1'b0;
    endtask

    // Observes the DUT from cycle T+1 until the response pulse; no checking here.
    task automatic wait_rsp(input int stall, output rsp_t o);
        int n;
        n = 1;
        o.rd_cnt = 0; o.tag_cnt = 0; o.bad_way = 0; o.ready_seen = 1'b0; o.timeout = 1'b1;
        o.lat = 0; o.data_en = 1'b0; o.wr_en = 1'b0; o.wr_state = CACHE_I; o.wr_way = '0;
        o.wr_addr = 32'h0; o.data = '0; o.lock_rsp = 1'b0;
        for (int i = 0; i < 80; i++) begin
            array_gnt_i = (n > stall);
            #1;
            if (snoop_ready_o) o.ready_seen = 1'b1;
            if (tag_rd_en_o) begin
                o.tag_cnt++;
                if (tag_rd_addr_o !== {snoop_addr_i[31:5], 5'd0} && !snoop_valid_i) o.bad_way++;
            end
            if (data_rd_en_o) begin
                o.rd_cnt++;
                if (data_rd_way_o !== tag_rd_way_i) o.bad_way++;
            end
            if (snoop_rsp_valid_o) begin
                o.lat = n; o.data_en = snoop_rsp_data_en_o; o.wr_en = state_wr_en_o;
                o.wr_state = state_wr_state_o; o.wr_way = state_wr_way_o; o.wr_addr = state_wr_addr_o;
                o.data = snoop_rsp_data_o; o.lock_rsp = array_lock_o; o.timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({snoop_ready_o, snoop_rsp_valid_o, array_req_o, array_lock_o, data_rd_en_o, state_wr_en_o} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_outputs: got %b expected 000000",
                {snoop_ready_o, snoop_rsp_valid_o, array_req_o, array_lock_o, data_rd_en_o, state_wr_en_o});
        end
        tests_run++;
        if (snoop_rsp_data_o !== '0) begin
            tests_failed++; $display("FAIL reset_buffer: got %h expected 0", snoop_rsp_data_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (snoop_ready_o !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready_after_release: got %b expected 1", snoop_ready_o);
        end
    endtask

    logic [1:0]              r_type [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd0};
    logic                    r_hit  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [L1_WAY_WIDTH-1:0] r_way  [7] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd3, 2'd1, 2'd2};
    cache_state_t            r_state[7] = '{CACHE_M, CACHE_E, CACHE_M, CACHE_S, CACHE_M, CACHE_M, CACHE_E};
    addr_t                   r_addr [7] = '{32'h0000_1234, 32'h0000_2048, 32'h0000_30FC,
                                            32'h0000_4000, 32'h8000_005C, 32'h0000_6010, 32'h0000_7FFF};

    task automatic test_basic_snoops();
        rsp_t e, o;
        for (int r = 0; r < 7; r++) begin
            e = model_rsp(r_type[r], r_addr[r], r_hit[r], r_way[r], r_state[r], 0);
            exp_q.push_back(e);
            drive_snoop(r_type[r], r_addr[r], r_hit[r], r_way[r], r_state[r]);
            wait_rsp(0, o);
            e = exp_q.pop_front();
            exp_buf = e.data;
            tests_run++;
            if (o.timeout) begin
                tests_failed++; $display("FAIL basic[%0d] timeout: no response within bound", r);
                continue;
            end
            tests_run++;
            if (o.lat !== e.lat || o.data_en !== e.data_en || o.wr_en !== e.wr_en) begin
                tests_failed++; $display("FAIL basic[%0d] lat/data_en/wr_en: got %0d/%b/%b expected %0d/%b/%b",
                    r, o.lat, o.data_en, o.wr_en, e.lat, e.data_en, e.wr_en);
            end
            if (e.wr_en) begin
                tests_run++;
                if (o.wr_state !== e.wr_state || o.wr_way !== e.wr_way || o.wr_addr !== e.wr_addr) begin
                    tests_failed++; $display("FAIL basic[%0d] state_wr: got %0d/%0d/%h expected %0d/%0d/%h",
                        r, o.wr_state, o.wr_way, o.wr_addr, e.wr_state, e.wr_way, e.wr_addr);
                end
            end
            tests_run++;
            if (o.data !== e.data) begin
                tests_failed++; $display("FAIL basic[%0d] rsp_data: got %h expected %h", r, o.data, e.data);
            end
            tests_run++;
            if (o.rd_cnt !== e.rd_cnt || o.tag_cnt !== e.tag_cnt || o.bad_way !== e.bad_way) begin
                tests_failed++; $display("FAIL basic[%0d] reads data/tag/bad: got %0d/%0d/%0d expected %0d/%0d/%0d",
                    r, o.rd_cnt, o.tag_cnt, o.bad_way, e.rd_cnt, e.tag_cnt, e.bad_way);
            end
            tests_run++;
            if (o.lock_rsp !== e.lock_rsp || o.ready_seen !== e.ready_seen) begin
                tests_failed++; $display("FAIL basic[%0d] lock/ready_busy: got %b/%b expected %b/%b",
                    r, o.lock_rsp, o.ready_seen, e.lock_rsp, e.ready_seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e, o;
        exp_q.push_back(model_rsp(2'd1, 32'h0000_9000, 1'b1, 2'd1, CACHE_E, 5));
        drive_snoop(2'd1, 32'h0000_9000, 1'b1, 2'd1, CACHE_E);
        snoop_addr_i = 32'h0000_A020; snoop_type_i = COH_READ_SHARED; snoop_valid_i = 1'b1;
        wait_rsp(5, o);
        e = exp_q.pop_front();
        tests_run++;
        if (o.timeout || o.lat !== e.lat || o.wr_state !== e.wr_state || o.wr_en !== e.wr_en) begin
            tests_failed++; $display("FAIL stall_first: timeout %b got lat %0d wr %b/%0d expected lat %0d wr %b/%0d",
                o.timeout, o.lat, o.wr_en, o.wr_state, e.lat, e.wr_en, e.wr_state);
        end
        tests_run++;
        if (o.ready_seen !== 1'b0 || o.tag_cnt !== 1) begin
            tests_failed++; $display("FAIL stall_ready_tag: got ready_seen %b tag_cnt %0d expected 0 and 1",
                o.ready_seen, o.tag_cnt);
        end
        exp_q.push_back(model_rsp(2'd0, 32'h0000_A020, 1'b1, 2'd1, CACHE_E, 0));
        @(posedge clk); #1;
        tests_run++;
        if (snoop_ready_o !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_ready_after_resp: got %b expected 1", snoop_ready_o);
        end
        @(posedge clk); #1;
        snoop_valid_i = 1'b0;
        wait_rsp(0, o);
        e = exp_q.pop_front();
        tests_run++;
        if (o.timeout || o.lat !== e.lat || o.wr_state !== e.wr_state || o.wr_addr !== e.wr_addr) begin
            tests_failed++; $display("FAIL b2b_second: timeout %b got lat %0d %0d %h expected lat %0d %0d %h",
                o.timeout, o.lat, o.wr_state, o.wr_addr, e.lat, e.wr_state, e.wr_addr);
        end
    endtask

    task automatic test_reset_mid_data();
        int bad_rsp;
        drive_snoop(2'd0, 32'h0000_B000, 1'b1, 2'd2, CACHE_M);
        array_gnt_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (data_rd_en_o !== 1'b1 || data_rd_addr_o !== 32'h0000_B00C) begin
            tests_failed++; $display("FAIL mid_data_position: got en %b addr %h expected 1 0000b00c",
                data_rd_en_o, data_rd_addr_o);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({snoop_ready_o, snoop_rsp_valid_o, snoop_rsp_data_en_o, array_req_o, array_lock_o,
             tag_rd_en_o, data_rd_en_o, state_wr_en_o} !== 8'b0 || snoop_rsp_data_o !== '0) begin
            tests_failed++; $display("FAIL mid_reset_outputs: got %b data %h expected all zero",
                {snoop_ready_o, snoop_rsp_valid_o, snoop_rsp_data_en_o, array_req_o, array_lock_o,
                 tag_rd_en_o, data_rd_en_o, state_wr_en_o}, snoop_rsp_data_o);
        end
        exp_buf = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        bad_rsp = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (snoop_rsp_valid_o || state_wr_en_o || array_lock_o) bad_rsp++;
        end
        tests_run++;
        if (bad_rsp !== 0 || snoop_ready_o !== 1'b1) begin
            tests_failed++; $display("FAIL mid_reset_abort: got %0d stray cycles ready %b expected 0 and 1",
                bad_rsp, snoop_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic_snoops();
        test_back_to_back();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/l1_snoop_responder.md
L1_SNOOP_RESPONDER -- requirements
Module: l1_snoop_responder

Interface
REQ-001 SHALL have clock port clk; all state on rising edge.
REQ-002 SHALL have reset port rst, input, 1 bit: asynchronous, active-high.
REQ-003 SHALL have snoop_valid_i, input, 1: snoop request from coherency controller.
REQ-004 SHALL have snoop_ready_o, output, 1: responder accepts a snoop.
REQ-005 SHALL have snoop_addr_i, input, addr_t: snooped line address.
REQ-006 SHALL have snoop_type_i, input, coherency_req_type_e: snoop kind.
REQ-007 SHALL have snoop_rsp_valid_o, output, 1: single-cycle response pulse; no ready.
REQ-008 SHALL have snoop_rsp_data_en_o, output, 1: response carries line data.
REQ-009 SHALL have snoop_rsp_data_o, output, word_t x L1_WORDS_PER_LINE: line data.
REQ-010 SHALL have array_req_o (out, 1), array_gnt_i (in, 1), array_lock_o (out, 1): L1 array arbitration with core pipeline.
REQ-011 SHALL have tag_rd_en_o (out, 1), tag_rd_addr_o (out, addr_t), tag_rd_hit_i (in, 1), tag_rd_way_i (in, L1_WAY_WIDTH), tag_rd_state_i (in, cache_state_t); results valid cycle after tag_rd_en_o.
REQ-012 SHALL have data_rd_en_o (out, 1), data_rd_way_o (out, L1_WAY_WIDTH), data_rd_addr_o (out, addr_t, word-aligned), data_rd_data_i (in, word_t); 1-cycle read latency.
REQ-013 SHALL have state_wr_en_o (out, 1), state_wr_addr_o (out, addr_t), state_wr_way_o (out, L1_WAY_WIDTH), state_wr_state_o (out, cache_state_t).

Function
REQ-014 SHALL implement FSM IDLE, LOOKUP, TAG_WAIT, DATA, RESP; one snoop in flight.
REQ-015 IDLE: snoop_ready_o=1; on valid&ready capture addr (line-aligned) and type, go LOOKUP; ready=0 in all other states.
REQ-016 LOOKUP: array_req_o=1; when array_gnt_i=1 same cycle, assert tag_rd_en_o, go TAG_WAIT; else stay, no tag read.
REQ-017 array_lock_o SHALL be 1 from TAG_WAIT through RESP inclusive, else 0.
REQ-018 TAG_WAIT: capture hit/way/state; go DATA if hit, state M and type in {READ_SHARED, READ_EXCL, INVALIDATE}; else RESP.
REQ-019 DATA: counter 0..W (W=L1_WORDS_PER_LINE); reads word k at count k<W; capture word k-1 into buffer at count k>=1; at count W go RESP; DATA lasts W+1 cycles.
REQ-020 Next state: READ_SHARED M/E->S, S->S; READ_EXCL and INVALIDATE M/E/S->I; I/miss unchanged; unknown types no-op, no data.
REQ-021 RESP (one cycle): snoop_rsp_valid_o=1; data_en=1 only if DATA visited; state_wr_en_o=1 only on hit with next state != current; then IDLE.
REQ-022 Latency from handshake cycle T: RESP at T+3 without data, T+4+W with data, plus grant-stall cycles.
REQ-023 snoop_rsp_data_o SHALL hold buffer contents; buffer unchanged on no-data snoops.
REQ-024 snoop_valid_i while busy SHALL be held off, accepted IDLE cycle after RESP.

Reset
REQ-025 rst SHALL force IDLE, counter 0, buffer 0, all outputs 0 except snoop_ready_o=1 after release.
REQ-026 rst mid-operation SHALL abort: no response, no state write, lock dropped immediately.

Structure
REQ-027 coherency_req_type_e, cache_state_t (MESI), L1_WORDS_PER_LINE (=CONFIG_CACHE_LINE_SIZE/4), L1_WAY_WIDTH SHALL live in riscv_config_pkg.
REQ-028 Single flat module; no sub-modules.

Verification
REQ-029 READ_SHARED hit M way 2, data_rd_data_i=0xA000_0000+k -> RESP at T+4+W, data_en=1, data[k]=0xA000_0000+k, state_wr S way 2.
REQ-030 READ_EXCL hit E -> RESP at T+3, data_en=0, state_wr I; no data reads.
REQ-031 INVALIDATE miss -> RESP at T+3, data_en=0, state_wr_en_o=0.
REQ-032 READ_SHARED hit S -> RESP at T+3, state_wr_en_o=0.
REQ-033 Grant held low 5 cycles, second snoop_valid asserted meanwhile -> RESP at T+8, ready=0 throughout, second accepted cycle after RESP.
REQ-034 rst pulsed in DATA count 3 -> next cycle all outputs 0, no snoop_rsp_valid_o, IDLE after release.
